// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake.
// Optional two-entry skid buffer, flush, and saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Flush,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [DATA_W-1:0] i_Data,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [DATA_W-1:0] o_Data,
  output logic [1:0]        o_Occupancy,
  output logic [CNT_W-1:0]  o_StallCount
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q;
  logic up, dn;

  assign o_Valid     = (state_q != EMPTY);
  assign o_Data      = main_q;
  assign o_Occupancy = state_q;
  assign o_StallCount = stall_q;

  assign up = i_Valid && o_Ready;
  assign dn = o_Valid && i_Ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up) begin
          state_d = ONE;
          main_d  = i_Data;
        end
      end
      ONE: begin
        if (up && dn) begin
          main_d = i_Data;
        end else if (up) begin
          // only reachable with the skid entry present
          if (SKID != 0) begin
            state_d = TWO;
            skid_d  = i_Data;
          end
        end else if (dn) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (dn) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (i_Flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stall_q <= '0;
    end else if (o_Valid && !i_Ready && stall_q != '1) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // ready comes straight from a flop: no i_Ready-to-o_Ready path
      logic rdy_q;
      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_d != TWO);
        end
      end
      assign o_Ready = rdy_q;
    end else begin : g_single
      assign o_Ready = !o_Valid || i_Ready;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry skid stage with registered o_Ready; 0 = single-entry stage with combinational o_Ready.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-004 SHALL have port i_Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port i_Flush, input, 1 bit: synchronous flush request from the hazard unit.
REQ-007 SHALL have port i_Valid, input, 1 bit: upstream payload is valid.
REQ-008 SHALL have port o_Ready, output, 1 bit: stage accepts the upstream payload this cycle.
REQ-009 SHALL have port i_Data, input, DATA_W bits: upstream payload.
REQ-010 SHALL have port o_Valid, output, 1 bit: o_Data is valid.
REQ-011 SHALL have port i_Ready, input, 1 bit: downstream accepts o_Data this cycle.
REQ-012 SHALL have port o_Data, output, DATA_W bits: registered payload to the next stage.
REQ-013 SHALL have port o_Occupancy, output, 2 bits: number of held entries, 0..2.
REQ-014 SHALL have port o_StallCount, output, CNT_W bits: saturating count of back-pressure cycles.

Function
REQ-015 SHALL treat a cycle with i_Valid && o_Ready as an upstream transfer, and a cycle with o_Valid && i_Ready as a downstream transfer.
REQ-016 SHALL, when SKID=1, implement states EMPTY (occupancy 0), ONE (occupancy 1, main register valid) and TWO (occupancy 2, main and skid registers valid).
REQ-017 SHALL apply the following SKID=1 transitions:
- EMPTY + upstream transfer -> ONE, main <= i_Data.
- ONE + upstream transfer + downstream transfer -> ONE, main <= i_Data.
- ONE + upstream transfer only -> TWO, skid <= i_Data.
- ONE + downstream transfer only -> EMPTY.
- TWO + downstream transfer -> ONE, main <= skid.
- No transfer -> hold state and data.
REQ-018 SHALL, when SKID=1, drive o_Ready = (state != TWO) directly from a register, with no combinational path from i_Ready.
REQ-019 SHALL, when SKID=0, hold at most one entry and drive o_Ready = !o_Valid || i_Ready (combinational).
REQ-020 SHALL drive o_Valid = (occupancy != 0) and o_Data = main register, with one-cycle latency from upstream transfer to o_Valid in EMPTY.
REQ-021 SHALL preserve order: the entry in the skid register always leaves after the main entry; no payload is duplicated or dropped except by flush or reset.
REQ-022 SHALL, when i_Flush=1 at a clock edge, go to EMPTY, set main and skid registers to all-zero, and discard any upstream transfer in that cycle.
REQ-023 SHALL treat any downstream transfer in a flush cycle as completed.
REQ-024 SHALL give i_Reset priority over i_Flush.
REQ-025 SHALL leave o_Ready computed normally during a flush cycle.
REQ-026 SHALL increment o_StallCount by 1 each cycle with o_Valid && !i_Ready, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL NOT clear o_StallCount on flush.
REQ-028 SHALL ignore i_Data whenever i_Valid=0.
REQ-029 SHALL NOT require i_Valid to be held or i_Data to be stable while o_Ready=0.

Reset
REQ-030 SHALL, on i_Reset=1 at a clock edge, set the state to EMPTY, o_Valid=0, o_Data=0, skid register=0, o_Occupancy=0 and o_StallCount=0.
REQ-031 SHALL set o_Ready=1 on the cycle after reset.
REQ-032 SHALL apply reset asserted mid-operation (any state, any handshake) identically to REQ-030, discarding all held data.

Verification
REQ-033 SHALL cover streaming: SKID=1, DATA_W=32, i_Ready=1, i_Valid=1 with data 1,2,3,4 on consecutive cycles -> o_Data 1,2,3,4 one cycle later, o_Occupancy=1 throughout, o_StallCount=0.
REQ-034 SHALL cover back-pressure: send 0xA then 0xB with i_Ready=0 -> o_Occupancy=2, o_Ready=0, o_Data=0xA; then raise i_Ready -> 0xA then 0xB are delivered, o_StallCount=2 after the two stalled cycles.
REQ-035 SHALL cover flush in TWO: after REQ-034 fill, assert i_Flush with i_Valid=1 and data 0xC -> next cycle o_Valid=0, o_Occupancy=0, o_Data=0, 0xC never appears, o_StallCount unchanged.
REQ-036 SHALL cover saturation: CNT_W=4, hold o_Valid=1 and i_Ready=0 for 20 cycles -> o_StallCount stops at 15.
REQ-037 SHALL cover reset versus flush: assert i_Reset and i_Flush together in state ONE -> all outputs as REQ-030, including o_StallCount=0.
REQ-038 SHALL cover SKID=0: with i_Ready=0 and o_Valid=1 -> o_Ready=0 in the same cycle; raising i_Ready -> o_Ready=1 combinationally, and a simultaneous upstream transfer replaces o_Data next cycle.
